fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the IF/ID latch. It owns the program counter and drives the instruction-memory read port. It forwards each fetched word with its PC+4 to the IF/ID latch, and suppresses latching when the word must be dropped. It absorbs control-flow redirects that arrive while an instruction-cache miss is outstanding, and halts fetch on HALT.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS core.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem read port and feeds IF/ID.
// Redirects that arrive during an outstanding miss are parked until the miss completes.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t imemload,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output logic  imemREN,
  output word_t imemaddr,
  output word_t instruction,
  output word_t pc_src,
  output logic  disable_fetch
);

  word_t        pc, pc_next;
  word_t        pend_pc, pend_pc_next;
  fetch_state_t state, state_next;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc      <= PC_INIT;
      pend_pc <= '0;
      state   <= FETCH;
    end else begin
      pc      <= pc_next;
      pend_pc <= pend_pc_next;
      state   <= state_next;
    end
  end

  // Next-PC selection and FSM transitions
  always_comb begin
    pc_next      = pc;
    pend_pc_next = pend_pc;
    state_next   = state;
    unique case (state)
      FETCH: begin
        if (redirect && ihit) begin
          pc_next = redirect_pc;
        end else if (redirect) begin
          // Keep pc so the cache can finish the request it is working on
          pend_pc_next = redirect_pc;
          state_next   = SQUASH;
        end else if (halt) begin
          state_next = HALTED;
        end else if (!stall && ihit) begin
          pc_next = pc + 32'd4;
        end
      end
      SQUASH: begin
        if (redirect) pend_pc_next = redirect_pc;
        if (ihit) begin
          pc_next    = redirect ? redirect_pc : pend_pc;
          state_next = FETCH;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign imemaddr      = pc;
  assign imemREN       = (state != HALTED);
  assign instruction   = ihit ? imemload : 32'h0000_0000;
  assign pc_src        = pc + 32'd4;
  assign disable_fetch = stall | redirect | (state != FETCH);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, misses, redirects, stall, halt, wrap.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic  CLK;
  logic  RST;
  logic  ihit;
  word_t imemload;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  logic  imemREN;
  word_t imemaddr;
  word_t instruction;
  word_t pc_src;
  logic  disable_fetch;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .instruction(instruction),
    .pc_src(pc_src), .disable_fetch(disable_fetch)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 0; imemload = '0; stall = 0; redirect = 0; redirect_pc = '0; halt = 0;
  endtask

  task automatic test_reset();
    RST = 1; idle_inputs();
    #2;
    checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want %h", imemaddr, 32'h0); end
    checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL reset_ren got %b want 1", imemREN); end
    checks++; if (pc_src !== 32'h4) begin errors++; $display("FAIL reset_pcsrc got %h want %h", pc_src, 32'h4); end
    checks++; if (disable_fetch !== 1'b0) begin errors++; $display("FAIL reset_disable got %b want 0", disable_fetch); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instruction); end
    ihit = 1; imemload = 32'hDEAD_BEEF; #1;
    checks++; if (instruction !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_instr_hit got %h want deadbeef", instruction); end
    ihit = 0;
    @(negedge CLK); RST = 0;
    #1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      ihit = 1; imemload = 32'h2000_0000 + 32'(i); #1;
      checks++; if (imemaddr !== 32'(4*i)) begin errors++; $display("FAIL seq_addr%0d got %h want %h", i, imemaddr, 32'(4*i)); end
      checks++; if (pc_src !== 32'(4*i+4)) begin errors++; $display("FAIL seq_pcsrc%0d got %h want %h", i, pc_src, 32'(4*i+4)); end
      checks++; if (disable_fetch !== 1'b0) begin errors++; $display("FAIL seq_disable%0d got %b want 0", i, disable_fetch); end
      checks++; if (instruction !== 32'h2000_0000 + 32'(i)) begin errors++; $display("FAIL seq_instr%0d got %h", i, instruction); end
      tick();
    end
    ihit = 0; #1;
    checks++; if (imemaddr !== 32'h10) begin errors++; $display("FAIL seq_final got %h want 10", imemaddr); end
  endtask

  task automatic test_miss();
    ihit = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (imemaddr !== 32'h10) begin errors++; $display("FAIL miss_hold%0d got %h want 10", i, imemaddr); end
      checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL miss_nop%0d got %h want 0", i, instruction); end
    end
    ihit = 1; imemload = 32'h1111_2222;
    tick();
    ihit = 0; #1;
    checks++; if (imemaddr !== 32'h14) begin errors++; $display("FAIL miss_advance got %h want 14", imemaddr); end
  endtask

  task automatic test_redirect_hit();
    redirect = 1; redirect_pc = 32'h20; ihit = 1; #1;
    checks++; if (disable_fetch !== 1'b1) begin errors++; $display("FAIL redir_hit_disable got %b want 1", disable_fetch); end
    tick();
    idle_inputs(); #1;
    checks++; if (imemaddr !== 32'h20) begin errors++; $display("FAIL redir_hit_addr got %h want 20", imemaddr); end
  endtask

  task automatic test_squash();
    redirect = 1; redirect_pc = 32'h400; ihit = 0;
    tick();
    redirect_pc = 32'h800; #1;
    checks++; if (dut.state !== SQUASH) begin errors++; $display("FAIL squash_state got %0d want %0d", dut.state, SQUASH); end
    checks++; if (imemaddr !== 32'h20) begin errors++; $display("FAIL squash_addr got %h want 20", imemaddr); end
    tick();
    redirect = 0; #1;
    checks++; if (disable_fetch !== 1'b1) begin errors++; $display("FAIL squash_disable got %b want 1", disable_fetch); end
    checks++; if (imemaddr !== 32'h20) begin errors++; $display("FAIL squash_hold got %h want 20", imemaddr); end
    // halt and stall must not matter while squashing
    halt = 1; stall = 1;
    tick();
    halt = 0; stall = 0; ihit = 1; imemload = 32'hBAD0_0020; #1;
    checks++; if (disable_fetch !== 1'b1) begin errors++; $display("FAIL squash_drop got %b want 1", disable_fetch); end
    tick();
    ihit = 0; #1;
    checks++; if (imemaddr !== 32'h800) begin errors++; $display("FAIL squash_target got %h want 800", imemaddr); end
    checks++; if (disable_fetch !== 1'b0) begin errors++; $display("FAIL squash_exit got %b want 0", disable_fetch); end
    // exit from SQUASH with a fresh redirect on the hit cycle
    redirect = 1; redirect_pc = 32'h900;
    tick();
    redirect_pc = 32'h40; ihit = 1;
    tick();
    idle_inputs(); #1;
    checks++; if (imemaddr !== 32'h40) begin errors++; $display("FAIL squash_latest got %h want 40", imemaddr); end
  endtask

  task automatic test_stall();
    stall = 1; ihit = 1; #1;
    checks++; if (disable_fetch !== 1'b1) begin errors++; $display("FAIL stall_disable got %b want 1", disable_fetch); end
    tick();
    checks++; if (imemaddr !== 32'h40) begin errors++; $display("FAIL stall_hold got %h want 40", imemaddr); end
    stall = 0;
    tick();
    ihit = 0; #1;
    checks++; if (imemaddr !== 32'h44) begin errors++; $display("FAIL stall_release got %h want 44", imemaddr); end
  endtask

  task automatic test_halt();
    redirect = 1; redirect_pc = 32'h60; ihit = 1;
    tick();
    idle_inputs(); halt = 1;
    tick();
    halt = 0; #1;
    checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL halt_ren got %b want 0", imemREN); end
    checks++; if (disable_fetch !== 1'b1) begin errors++; $display("FAIL halt_disable got %b want 1", disable_fetch); end
    redirect = 1; redirect_pc = 32'h123; ihit = 1;
    tick();
    idle_inputs(); ihit = 1;
    tick();
    ihit = 0; #1;
    checks++; if (imemaddr !== 32'h60) begin errors++; $display("FAIL halt_frozen got %h want 60", imemaddr); end
    checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL halt_stays got %b want 0", imemREN); end
    #2 RST = 1; #1;
    checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL halt_reset_addr got %h want 0", imemaddr); end
    checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL halt_reset_ren got %b want 1", imemREN); end
    @(negedge CLK); RST = 0; #1;
  endtask

  task automatic test_wrap();
    redirect = 1; redirect_pc = 32'hFFFF_FFFC; ihit = 1;
    tick();
    idle_inputs(); #1;
    checks++; if (imemaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h want fffffffc", imemaddr); end
    checks++; if (pc_src !== 32'h0) begin errors++; $display("FAIL wrap_pcsrc got %h want 0", pc_src); end
    ihit = 1;
    tick();
    ihit = 0; #1;
    checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 0", imemaddr); end
    checks++; if (pc_src !== 32'h4) begin errors++; $display("FAIL wrap_next_pcsrc got %h want 4", pc_src); end
  endtask

  task automatic test_reset_in_squash();
    redirect = 1; redirect_pc = 32'h7700; ihit = 0;
    tick();
    idle_inputs(); #1;
    checks++; if (dut.state !== SQUASH) begin errors++; $display("FAIL rsq_enter got %0d want %0d", dut.state, SQUASH); end
    #2 RST = 1; #1;
    checks++; if (dut.state !== FETCH) begin errors++; $display("FAIL rsq_state got %0d want %0d", dut.state, FETCH); end
    checks++; if (dut.pend_pc !== 32'h0) begin errors++; $display("FAIL rsq_pend got %h want 0", dut.pend_pc); end
    @(negedge CLK); RST = 0; ihit = 1;
    tick();
    ihit = 0; #1;
    checks++; if (imemaddr !== 32'h4) begin errors++; $display("FAIL rsq_resume got %h want 4", imemaddr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_miss();
    test_redirect_hit();
    test_squash();
    test_stall();
    test_halt();
    test_wrap();
    test_reset_in_squash();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
